// File: rtl/led_cmd_pkg.sv
// Shared definitions for the LED command scheduler: opcodes, FSM encoding
// and the opcode legality check.
package led_cmd_pkg;

   localparam logic [7:0] OP_CLR = 8'h00;
   localparam logic [7:0] OP_SET = 8'h01;
   localparam logic [7:0] OP_RST = 8'h02;
   localparam logic [7:0] OP_TGL = 8'h03;
   localparam logic [7:0] OP_XNR = 8'h04;
   localparam logic [7:0] OP_INV = 8'h05;
   localparam logic [7:0] OP_FRC = 8'h10;
   localparam logic [7:0] OP_RDB = 8'h20;  // readback (copy) opcode

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPC    = 3'd1,
      ST_DAT    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RDBK   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   function automatic logic is_legal_op(input logic [7:0] op);
      case (op)
         OP_CLR, OP_SET, OP_RST, OP_TGL,
         OP_XNR, OP_INV, OP_FRC, OP_RDB: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. last_q holds the index of the most
// recently granted requester; on a tie the other requester wins. The
// pointer only moves when the caller reports a completed handshake.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   logic last_q;

   // Grant selection: a lone requester always wins, a tie goes to the one not last granted.
   always_comb begin
      gnt_idx = 1'b0;
      gnt     = 2'b00;
      if (req == 2'b11) begin
         gnt_idx = ~last_q;
      end else if (req == 2'b10) begin
         gnt_idx = 1'b1;
      end
      if (req != 2'b00) begin
         gnt = gnt_idx ? 2'b10 : 2'b01;
      end
   end

   // Pointer register; resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (update) begin
         last_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/led_cmd_sched.sv
// LED command scheduler: arbitrates two requesters, serialises each command
// into a two-beat LOAD burst (opcode, then operand) and returns a one-cycle
// response to the issuing requester.
//
// Handshake: a command transfers on the MCLK edge where REQ_VALID[i] and
// REQ_READY[i] are both high. A requester holds VALID/OP/DATA stable until
// then; READY is only ever high in IDLE, for the granted requester alone.
//
// All LOAD/POUT/RSP_* outputs are registered from the next-state decode, so
// each value appears in the cycle the FSM spends in the corresponding state.
module led_cmd_sched
   import led_cmd_pkg::*;
(
   input  logic        MCLK,
   input  logic        nRST,
   input  logic [1:0]  REQ_VALID,
   input  logic [15:0] REQ_OP,
   input  logic [15:0] REQ_DATA,
   output logic [1:0]  REQ_READY,
   output logic [1:0]  RSP_VALID,
   output logic [7:0]  RSP_DATA,
   output logic        RSP_ERR,
   output logic        LOAD,
   output logic [7:0]  POUT,
   input  logic [7:0]  PIN,
   output logic        BUSY
);

   state_t     state_q, state_n;
   logic [7:0] op_q, data_q;
   logic       gnt_q;
   logic [1:0] arb_gnt;
   logic       arb_idx;
   logic       hs;
   logic [7:0] sel_op, sel_data;
   logic [1:0] gnt_vec;

   logic       load_n;
   logic [7:0] pout_n;
   logic [1:0] rsp_valid_n;
   logic [7:0] rsp_data_n;
   logic       rsp_err_n;

   rr_arb2 u_arb (
      .clk     (MCLK),
      .rst_n   (nRST),
      .req     (REQ_VALID),
      .update  (hs),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign sel_op    = arb_idx ? REQ_OP[15:8]   : REQ_OP[7:0];
   assign sel_data  = arb_idx ? REQ_DATA[15:8] : REQ_DATA[7:0];
   assign hs        = (state_q == ST_IDLE) && (arb_gnt != 2'b00);
   assign REQ_READY = ((state_q == ST_IDLE) && nRST) ? arb_gnt : 2'b00;
   assign BUSY      = (state_q != ST_IDLE);
   assign gnt_vec   = gnt_q ? 2'b10 : 2'b01;

   // Next-state and next-output decode.
   always_comb begin
      state_n     = state_q;
      load_n      = 1'b0;
      pout_n      = 8'h00;
      rsp_valid_n = 2'b00;
      rsp_data_n  = 8'h00;
      rsp_err_n   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (!is_legal_op(sel_op)) begin
                  state_n     = ST_ERR;
                  rsp_valid_n = arb_gnt;
                  rsp_err_n   = 1'b1;
               end else begin
                  state_n = ST_OPC;
                  load_n  = 1'b1;
                  pout_n  = sel_op;
               end
            end
         end
         ST_OPC: begin
            state_n = ST_DAT;
            load_n  = 1'b1;
            pout_n  = data_q;
         end
         ST_DAT: begin
            state_n = ST_SETTLE;
            if (op_q != OP_RDB) begin
               rsp_valid_n = gnt_vec;
            end
         end
         ST_SETTLE: begin
            if (op_q == OP_RDB) begin
               state_n     = ST_RDBK;
               rsp_valid_n = gnt_vec;
               rsp_data_n  = PIN;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_RDBK: state_n = ST_IDLE;
         ST_ERR:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Command latches, captured on the handshake.
   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         op_q   <= 8'h00;
         data_q <= 8'h00;
         gnt_q  <= 1'b0;
      end else if (hs) begin
         op_q   <= sel_op;
         data_q <= sel_data;
         gnt_q  <= arb_idx;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= ST_IDLE;
         LOAD      <= 1'b0;
         POUT      <= 8'h00;
         RSP_VALID <= 2'b00;
         RSP_DATA  <= 8'h00;
         RSP_ERR   <= 1'b0;
      end else begin
         state_q   <= state_n;
         LOAD      <= load_n;
         POUT      <= pout_n;
         RSP_VALID <= rsp_valid_n;
         RSP_DATA  <= rsp_data_n;
         RSP_ERR   <= rsp_err_n;
      end
   end

endmodule

// File: tb/tb_led_cmd_sched.sv
// Bench for led_cmd_sched: directed scenarios followed by random traffic from
// both requesters. A reference model predicts grants, LOAD beats and
// responses with cycle stamps; a monitor pops and compares them.
module tb_led_cmd_sched;

   // ---------------- clock / reset ----------------
   logic MCLK = 1'b0;
   logic nRST = 1'b1;
   initial forever #5 MCLK = ~MCLK;

   int cyc = 0;
   always @(posedge MCLK) cyc <= cyc + 1;

   // ---------------- DUT hookup ----------------
   logic       valid0 = 1'b0, valid1 = 1'b0;
   logic [7:0] op0 = 8'h00, op1 = 8'h00, data0 = 8'h00, data1 = 8'h00;
   logic [7:0] PIN = 8'h00;
   wire  [1:0]  REQ_VALID = {valid1, valid0};
   wire  [15:0] REQ_OP    = {op1, op0};
   wire  [15:0] REQ_DATA  = {data1, data0};
   logic [1:0]  REQ_READY, RSP_VALID;
   logic [7:0]  RSP_DATA, POUT;
   logic        RSP_ERR, LOAD, BUSY;

   led_cmd_sched dut (
      .MCLK      (MCLK),
      .nRST      (nRST),
      .REQ_VALID (REQ_VALID),
      .REQ_OP    (REQ_OP),
      .REQ_DATA  (REQ_DATA),
      .REQ_READY (REQ_READY),
      .RSP_VALID (RSP_VALID),
      .RSP_DATA  (RSP_DATA),
      .RSP_ERR   (RSP_ERR),
      .LOAD      (LOAD),
      .POUT      (POUT),
      .PIN       (PIN),
      .BUSY      (BUSY)
   );

   // ---------------- bookkeeping ----------------
   int vectors = 0;
   int miscompares = 0;

   logic [7:0] legal_tab   [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h20};
   logic [7:0] illegal_tab [6] = '{8'h06, 8'h07, 8'h11, 8'h21, 8'h80, 8'hFF};

   // load entry: {cycle[15:0], pout[7:0]}
   logic [23:0] exp_load_q[$];
   // rsp entry: {cycle[15:0], valid[1:0], err, rdbk, data[7:0]}
   logic [27:0] exp_rsp_q[$];
   logic [7:0]  pin_hist[int];

   logic model_last = 1'b1;
   int   next_free  = 0;

   logic       pin_rand = 1'b1;
   logic [7:0] pin_fix  = 8'h00;

   initial forever begin
      @(posedge MCLK);
      #1;
      PIN = pin_rand ? 8'($urandom) : pin_fix;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit legal(input logic [7:0] op);
      return op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h20};
   endfunction

   // ---------------- reference model ----------------
   // Scheduler is free once next_free is reached; each accepted command
   // occupies it for 2 (illegal), 4 (write) or 5 (readback) cycles.
   always @(negedge MCLK) begin : model
      logic [1:0]  v;
      logic [1:0]  exp_rdy;
      logic        w;
      logic [7:0]  o, d;
      logic [15:0] c;
      if (!nRST) begin
         exp_load_q.delete();
         exp_rsp_q.delete();
         model_last = 1'b1;
         next_free  = 0;
      end else begin
         c = cyc[15:0];
         pin_hist[cyc] = PIN;
         v = {valid1, valid0};
         chk("busy", {7'b0, BUSY}, {7'b0, (cyc < next_free)});
         exp_rdy = 2'b00;
         if (cyc >= next_free && v != 2'b00) begin
            w = (v == 2'b11) ? ~model_last : v[1];
            exp_rdy = w ? 2'b10 : 2'b01;
            o = w ? op1 : op0;
            d = w ? data1 : data0;
            model_last = w;
            if (!legal(o)) begin
               exp_rsp_q.push_back({c + 16'd1, exp_rdy, 1'b1, 1'b0, 8'h00});
               next_free = cyc + 2;
            end else begin
               exp_load_q.push_back({c + 16'd1, o});
               exp_load_q.push_back({c + 16'd2, d});
               if (o == 8'h20) begin
                  exp_rsp_q.push_back({c + 16'd4, exp_rdy, 1'b0, 1'b1, 8'h00});
                  next_free = cyc + 5;
               end else begin
                  exp_rsp_q.push_back({c + 16'd3, exp_rdy, 1'b0, 1'b0, 8'h00});
                  next_free = cyc + 4;
               end
            end
         end
         chk("req_ready", {6'b0, REQ_READY}, {6'b0, exp_rdy});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge MCLK) begin : monitor
      logic [23:0] le;
      logic [27:0] re;
      logic [7:0]  want_d;
      if (nRST) begin
         if (LOAD) begin
            vectors++;
            if (exp_load_q.size() == 0) begin
               miscompares++;
               $display("FAIL load_unexpected: got LOAD=1 POUT=%h at cycle %0d, want no LOAD", POUT, cyc);
            end else begin
               le = exp_load_q.pop_front();
               if (le[23:8] !== cyc[15:0] || le[7:0] !== POUT) begin
                  miscompares++;
                  $display("FAIL load_beat: got cycle %0d POUT=%h, want cycle %0d POUT=%h",
                           cyc, POUT, le[23:8], le[7:0]);
               end
            end
         end else if (exp_load_q.size() != 0 && exp_load_q[0][23:8] <= cyc[15:0]) begin
            vectors++;
            miscompares++;
            le = exp_load_q.pop_front();
            $display("FAIL load_missing: got LOAD=0 at cycle %0d, want POUT=%h", cyc, le[7:0]);
         end

         if (RSP_VALID != 2'b00) begin
            vectors++;
            if (exp_rsp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rsp_unexpected: got RSP_VALID=%b at cycle %0d, want none", RSP_VALID, cyc);
            end else begin
               re = exp_rsp_q.pop_front();
               want_d = re[8] ? pin_hist[cyc - 1] : re[7:0];
               if (re[27:12] !== cyc[15:0] || re[11:10] !== RSP_VALID ||
                   re[9] !== RSP_ERR || want_d !== RSP_DATA) begin
                  miscompares++;
                  $display("FAIL rsp: got cyc=%0d vld=%b err=%b data=%h, want cyc=%0d vld=%b err=%b data=%h",
                           cyc, RSP_VALID, RSP_ERR, RSP_DATA, re[27:12], re[11:10], re[9], want_d);
               end
            end
         end else if (exp_rsp_q.size() != 0 && exp_rsp_q[0][27:12] <= cyc[15:0]) begin
            vectors++;
            miscompares++;
            re = exp_rsp_q.pop_front();
            $display("FAIL rsp_missing: got RSP_VALID=00 at cycle %0d, want vld=%b", cyc, re[11:10]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic send(input int i, input logic [7:0] o, input logic [7:0] d);
      bit hs;
      hs = 1'b0;
      if (i == 0) begin
         valid0 = 1'b1; op0 = o; data0 = d;
      end else begin
         valid1 = 1'b1; op1 = o; data1 = d;
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge MCLK);
         if (REQ_READY[i]) begin
            hs = 1'b1;
            break;
         end
      end
      vectors++;
      if (!hs) begin
         miscompares++;
         $display("FAIL handshake_timeout: got no REQ_READY for req%0d op=%h, want grant within 100 cycles", i, o);
      end
      @(posedge MCLK);
      #1;
      if (i == 0) valid0 = 1'b0;
      else        valid1 = 1'b0;
   endtask

   task automatic wait_load();
      for (int k = 0; k < 20; k++) begin
         @(negedge MCLK);
         if (LOAD) break;
      end
      chk("wait_load", {7'b0, LOAD}, 8'h01);
   endtask

   task automatic rand_req(input int i);
      repeat (30) begin
         int g;
         logic [7:0] o;
         g = $urandom_range(0, 3);
         repeat (g) begin
            @(posedge MCLK);
            #1;
         end
         if ($urandom_range(0, 7) == 0) o = illegal_tab[$urandom_range(0, 5)];
         else                           o = legal_tab[$urandom_range(0, 7)];
         send(i, o, 8'($urandom));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge MCLK);
         #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load"},      {7'b0, LOAD},      8'h00);
      chk({tag, "_pout"},      POUT,              8'h00);
      chk({tag, "_req_ready"}, {6'b0, REQ_READY}, 8'h00);
      chk({tag, "_rsp_valid"}, {6'b0, RSP_VALID}, 8'h00);
      chk({tag, "_rsp_data"},  RSP_DATA,          8'h00);
      chk({tag, "_rsp_err"},   {7'b0, RSP_ERR},   8'h00);
      chk({tag, "_busy"},      {7'b0, BUSY},      8'h00);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      #1 nRST = 1'b0;
      #3;
      chk_all_zero("reset");
      repeat (2) @(posedge MCLK);
      #1 nRST = 1'b1;
      idle(1);

      // simple write from requester 0
      send(0, 8'h01, 8'h0F);
      idle(3);

      // readback from requester 1 with a fixed PIN
      pin_fix = 8'hA5; pin_rand = 1'b0; PIN = 8'hA5;
      send(1, 8'h20, 8'hC3);
      idle(4);
      pin_rand = 1'b1;

      // both requesters hold valid continuously
      fork
         begin send(0, 8'h03, 8'hAA); send(0, 8'h03, 8'hAA); end
         begin send(1, 8'h10, 8'h55); send(1, 8'h10, 8'h55); end
      join
      idle(4);

      // illegal opcode
      send(0, 8'h07, 8'h11);
      idle(2);

      // reset during the operand beat
      fork
         send(0, 8'h02, 8'h33);
      join_none
      wait_load();
      @(posedge MCLK);
      #2 nRST = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (2) @(posedge MCLK);
      #1 nRST = 1'b1;
      fork
         send(0, 8'h04, 8'h5A);
         send(1, 8'h05, 8'hA5);
      join
      idle(4);

      // requester 1 arrives while requester 0 is in its opcode beat
      fork
         send(0, 8'h01, 8'h3C);
      join_none
      wait_load();
      send(1, 8'h02, 8'hC0);
      idle(4);

      // random traffic from both requesters
      fork
         rand_req(0);
         rand_req(1);
      join

      for (int k = 0; k < 50; k++) begin
         @(negedge MCLK);
         if (exp_load_q.size() == 0 && exp_rsp_q.size() == 0) break;
      end
      vectors++;
      if (exp_load_q.size() != 0 || exp_rsp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d load and %0d rsp entries outstanding, want 0",
                  exp_load_q.size(), exp_rsp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000, want finish");
      $fatal(1);
   end

endmodule

// File: doc/led_cmd_sched.md
# led_cmd_sched

Command scheduler for the LED management block. Accepts LED commands (opcode + operand) from two independent requesters, arbitrates round-robin and serialises each command into the LED block's two-beat LOAD protocol on POUT. For the copy opcode, it returns the LED block's PIN readback to the issuing requester. Sits between the host/sequencer logic and the LED management block, and is the only driver of its LOAD/POUT.

## Interface
- Parameters: none. The requester count is fixed at 2, and all widths are 8 bits.
- MCLK  in  1  main clock; all logic on posedge.
- nRST  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  2  per-requester command valid. Must hold, with OP/DATA stable, until the handshake.
- REQ_OP  in  16  opcodes: [7:0] is requester 0, [15:8] is requester 1.
- REQ_DATA  in  16  operands, same packing as REQ_OP.
- REQ_READY  out  2  accept strobe. Handshake is VALID & READY.
- RSP_VALID  out  2  one-cycle completion pulse to the issuing requester.
- RSP_DATA  out  8  readback value. Valid while any RSP_VALID bit is high.
- RSP_ERR  out  1  illegal opcode flag. Valid with RSP_VALID.
- LOAD  out  1  load strobe to the LED block.
- POUT  out  8  opcode/operand byte to the LED block.
- PIN  in  8  readback byte from the LED block.
- BUSY  out  1  high whenever state != IDLE.

## Operation
- Legal opcodes are 0x00, 0x01, 0x02, 0x03, 0x04, 0x05, 0x10 and 0x20. 0x20 is the readback (copy) opcode.
- State machine states are IDLE, OPC, DAT, SETTLE, RDBK and ERR.
- IDLE
  - If any REQ_VALID is high, the arbiter grants requester g, and REQ_READY[g] is driven combinationally high for that one cycle.
  - On the handshake, latch op, data and g.
  - Next state: ERR if op is illegal, otherwise OPC.
- OPC: LOAD=1, POUT=op, then go to DAT.
- DAT: LOAD=1, POUT=data, then go to SETTLE.
- SETTLE
  - LOAD=0 and POUT=0x00.
  - If op is 0x20, go to RDBK.
  - Otherwise pulse RSP_VALID[g] with RSP_DATA=0x00 and RSP_ERR=0, then go to IDLE.
- RDBK: register PIN into RSP_DATA, pulse RSP_VALID[g] with RSP_ERR=0, then go to IDLE.
- ERR: no LOAD is issued. Pulse RSP_VALID[g] with RSP_ERR=1 and RSP_DATA=0x00, then go to IDLE.
- Arbitration is two-way round-robin. The pointer records the last granted requester.
  - When both requesters are valid, the one not last granted wins.
  - After reset, requester 0 wins the first tie.
  - The pointer updates only on a handshake.
- A single valid requester is always granted, regardless of the pointer.
- REQ_READY is 0 outside IDLE. Requests arriving while BUSY wait; none are dropped.
- LOAD and POUT are registered outputs. RSP_VALID, RSP_DATA and RSP_ERR are registered outputs.

## Timing
- Reset values: LOAD=0, POUT=0x00, REQ_READY=0, RSP_VALID=0, RSP_DATA=0x00, RSP_ERR=0, BUSY=0, state=IDLE, RR pointer=1 (so requester 0 wins the first tie).
- Write command with handshake at cycle T:
  - LOAD is high at T+1 (opcode) and T+2 (operand).
  - RSP_VALID pulses at T+3.
  - The next handshake is possible at T+4, giving a 4-cycle period.
- Readback command: RSP_VALID pulses at T+4 with RSP_DATA = PIN sampled at the end of T+3. Period is 5 cycles.
- Illegal opcode: RSP_VALID and RSP_ERR pulse at T+1, LOAD stays 0, period is 2 cycles.
- LOAD is never high for more than 2 consecutive cycles, and is always followed by at least 1 low cycle.
- Reset mid-operation (nRST low in any state):
  - All outputs return to reset values immediately, without waiting for MCLK.
  - Any in-flight command is abandoned, with no response.
  - The RR pointer resets.
- A requester may raise REQ_VALID in the same cycle that its RSP_VALID pulses. The new request is handled in the following IDLE cycle.

## Structure
- Package led_cmd_pkg holds:
  - the opcode localparams (OP_CLR, OP_SET, OP_RST, OP_TGL, OP_XNR, OP_INV, OP_FRC, OP_RDB);
  - the state encoding;
  - the function is_legal_op(op).
- Sub-module rr_arb2 is the two-requester round-robin arbiter.
  - Inputs: req[1:0], the handshake-update strobe, and clock/reset.
  - Outputs: a one-hot grant and the grant index.
- The FSM, latches and output registers live in led_cmd_sched.

## Test plan
- Reset, then requester 0 sends op=0x01, data=0x0F.
  - Handshake at T.
  - LOAD=1 with POUT=0x01 at T+1 and POUT=0x0F at T+2.
  - RSP_VALID=2'b01, RSP_ERR=0 at T+3.
- Both requesters hold valid continuously, with requester 0 sending 0x03/0xAA and requester 1 sending 0x10/0x55.
  - Grant order is 0, 1, 0, 1.
  - Handshakes are exactly 4 cycles apart.
  - No requester is granted twice in a row.
- Requester 1 sends op=0x20 while the bench drives PIN=0xA5 from T+3.
  - LOAD at T+1 and T+2.
  - RSP_VALID=2'b10 at T+4 with RSP_DATA=0xA5.
- Requester 0 sends op=0x07.
  - LOAD stays 0.
  - At T+1, RSP_VALID=2'b01, RSP_ERR=1, RSP_DATA=0x00.
  - BUSY is high for exactly 1 cycle.
- Assert nRST low at T+2 of a write command (during the DAT beat).
  - LOAD, POUT, BUSY and RSP_* are 0 immediately, with no RSP pulse.
  - After release, a tie is won by requester 0.
- Requester 1 raises REQ_VALID while a requester 0 command is in OPC.
  - REQ_READY[1] stays 0 until IDLE.
  - The request is granted in the first IDLE cycle after completion.
